// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Lets two independent requesters share one external combinational ALU, for
//   example an execute stage and a debug or self-test engine. Requests arrive
//   over a valid/ready handshake and are arbitrated round-robin.
//
//   For each granted request the block:
//     1. registers the operands and opcode onto the ALU inputs,
//     2. waits one execute cycle,
//     3. captures the ALU result and flags, and
//     4. returns them to the owning requester over a held response handshake.
//
//   Illegal opcodes are screened. They never reach the ALU control input, and
//   they are answered with an error response. Each requester has a saturating
//   count of accepted requests.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   reqN_valid/reqN_ready   request handshake for requester N (0/1)
//   reqN_src1/reqN_src2     operands of requester N
//   reqN_op                 ALU control code of requester N
//   rspN_valid/rspN_ready   response handshake for requester N
//   rsp_result              captured result, shared, qualified by rspN_valid
//   rsp_zcv                 captured {zero, cout, overflow}
//   rsp_err                 response belongs to an illegal-opcode request
//   alu_src1/alu_src2       registered operands to the ALU
//   alu_ctrl                registered control code to the ALU
//   alu_result              result from the ALU
//   alu_zero/alu_cout/alu_overflow   flags from the ALU
//   busy                    a transaction is in flight (state != IDLE)
//   gnt_cnt0/gnt_cnt1       accepted-request counts, saturating at all-ones
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_src1,
    input  logic [WIDTH-1:0] req0_src2,
    input  logic [3:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_src1,
    input  logic [WIDTH-1:0] req1_src2,
    input  logic [3:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_zcv,
    output logic             rsp_err,

    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,

    output logic             busy,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcodes the shared ALU actually implements: AND, OR, ADD, SUB, SLT, NOR.
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: legal = 1'b1;
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t           r_state;
    logic             r_last_grant;   // requester served most recently (1 = req1)
    logic             r_owner;        // requester owning the in-flight transaction
    logic             r_err;          // in-flight request carried an illegal opcode
    logic             r_busy;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [2:0]       r_rsp_zcv;
    logic             r_rsp_err;
    logic [WIDTH-1:0] r_alu_src1;
    logic [WIDTH-1:0] r_alu_src2;
    logic [3:0]       r_alu_ctrl;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_src1;
    logic [WIDTH-1:0] w_sel_src2;
    logic [3:0]       w_sel_op;
    logic             w_rsp_taken;

    // Round-robin grant, offered only in IDLE and never while reset is asserted.
    // Because a grant is issued only to a requester whose valid is high, the
    // grant itself already means a handshake is taking place.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n && (r_state == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                if (r_last_grant) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (req0_valid) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    // Steer the granted requester's payload toward the ALU input registers.
    always_comb begin
        w_accept = w_gnt0 | w_gnt1;
        if (w_gnt1) begin
            w_sel_src1 = req1_src1;
            w_sel_src2 = req1_src2;
            w_sel_op   = req1_op;
        end else begin
            w_sel_src1 = req0_src1;
            w_sel_src2 = req0_src2;
            w_sel_op   = req0_op;
        end
    end

    // Only the owner's response ready retires the transaction.
    always_comb begin
        if (r_owner) begin
            w_rsp_taken = rsp1_ready;
        end else begin
            w_rsp_taken = rsp0_ready;
        end
    end

    // Transaction FSM together with every register it owns: ALU inputs,
    // response data, handshake outputs and grant counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_result <= {WIDTH{1'b0}};
            r_rsp_zcv    <= 3'b000;
            r_rsp_err    <= 1'b0;
            r_alu_src1   <= {WIDTH{1'b0}};
            r_alu_src2   <= {WIDTH{1'b0}};
            r_alu_ctrl   <= 4'd0;
            r_cnt0       <= {CNT_W{1'b0}};
            r_cnt1       <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_src1 <= w_sel_src1;
                        r_alu_src2 <= w_sel_src2;
                        // An illegal code must not reach the ALU, so the
                        // previous control value stays on the ALU control input.
                        if (is_legal_op(w_sel_op)) begin
                            r_alu_ctrl <= w_sel_op;
                            r_err      <= 1'b0;
                        end else begin
                            r_alu_ctrl <= r_alu_ctrl;
                            r_err      <= 1'b1;
                        end
                        r_owner <= w_gnt1;
                        if (w_gnt1) begin
                            if (r_cnt1 != {CNT_W{1'b1}}) begin
                                r_cnt1 <= r_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                r_cnt1 <= r_cnt1;
                            end
                        end else begin
                            if (r_cnt0 != {CNT_W{1'b1}}) begin
                                r_cnt0 <= r_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                r_cnt0 <= r_cnt0;
                            end
                        end
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_EXEC: begin
                    // The ALU inputs have been stable for a full cycle, so its
                    // combinational output is now settled and can be captured.
                    if (r_err) begin
                        r_rsp_result <= {WIDTH{1'b0}};
                        r_rsp_zcv    <= 3'b000;
                        r_rsp_err    <= 1'b1;
                    end else begin
                        r_rsp_result <= alu_result;
                        r_rsp_zcv    <= {alu_zero, alu_cout, alu_overflow};
                        r_rsp_err    <= 1'b0;
                    end
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= ST_RESP;
                end

                ST_RESP: begin
                    if (w_rsp_taken) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_last_grant <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end

                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zcv    = r_rsp_zcv;
    assign rsp_err    = r_rsp_err;
    assign alu_src1   = r_alu_src1;
    assign alu_src2   = r_alu_src2;
    assign alu_ctrl   = r_alu_ctrl;
    assign busy       = r_busy;
    assign gnt_cnt0   = r_cnt0;
    assign gnt_cnt1   = r_cnt1;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit `alu` instance between two independent requesters (e.g. an execute stage and a debug/self-test engine).
- Accepts requests over a valid/ready handshake and arbitrates round-robin.
- Registers the granted operands onto the ALU inputs, samples result and flags after one execute cycle, and returns them to the owning requester over a held response handshake.
- Also screens illegal opcodes and keeps per-requester grant counters.

Parameters:
- WIDTH, 32: operand/result width; must match the ALU.
- CNT_W, 16: width of the saturating grant counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- req0_valid / req1_valid  in  1  requester N has a request.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_src1, req0_src2, req1_src1, req1_src2  in  WIDTH  operands.
- req0_op / req1_op  in  4  ALU_control code.
- rsp0_valid / rsp1_valid  out  1  response N is valid.
- rsp0_ready / rsp1_ready  in  1  requester N consumes the response.
- rsp_result  out  WIDTH  captured result; shared bus, qualified by rspN_valid.
- rsp_zcv  out  3  captured {zero, cout, overflow}.
- rsp_err  out  1  request carried an illegal opcode.
- alu_src1, alu_src2  out  WIDTH  to ALU src1/src2.
- alu_ctrl  out  4  to ALU ALU_control.
- alu_result  in  WIDTH  from ALU result.
- alu_zero, alu_cout, alu_overflow  in  1  from ALU flags.
- busy  out  1  state != IDLE.
- gnt_cnt0 / gnt_cnt1  out  CNT_W  accepted-request count per requester, saturating at all-ones.

Behaviour:
- Legal opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. Every other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All rsp/ready/busy outputs 0.
  - rsp_result=0, rsp_zcv=0, rsp_err=0.
  - alu_src1/alu_src2/alu_ctrl=0.
  - Counters=0.
  - last_grant=1, so req0 wins the first tie.
  - Reset mid-transaction aborts it: no response is produced and the pending owner is discarded.
- IDLE:
  - Grant is combinational from the valids.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready=1 only for the granted requester, and only in IDLE.
  - On handshake (valid&ready):
    - Latch src1/src2/op into alu_src1/alu_src2/alu_ctrl. If the op is illegal, alu_ctrl keeps its previous value and the err flag is latched.
    - Record owner and increment gnt_cntN.
    - Go to EXEC.
  - With no valid, stay in IDLE; ALU-driving registers hold.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from the registers.
  - At the end of the cycle capture rsp_result<=alu_result and rsp_zcv<={alu_zero,alu_cout,alu_overflow}.
  - If err is set, capture rsp_result=0, rsp_zcv=000, rsp_err=1 instead.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid stays 0.
  - rsp_result/rsp_zcv/rsp_err are held stable while valid.
  - When rsp<owner>_ready=1: deassert valid the next cycle, set last_grant<=owner, go to IDLE.
  - rsp of the non-owner's ready is ignored.
- Latency: request accept edge -> rsp valid 2 cycles later. Minimum 3 cycles per transaction. Requests are never accepted in EXEC or RESP.
- A requester may drop its valid before ready. No request is lost once accepted. No ready is asserted to a requester whose valid is low.
- A counter at its maximum value stays there.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with both valids high -> no ready; all outputs 0; busy=0; release -> req0_ready=1 first.
- Single AND: req0 src1=0x0000FFFF, src2=0x00FF00FF, op=0 -> req0_ready in IDLE; rsp0_valid exactly 2 cycles later; rsp_result=0x000000FF; rsp_zcv=000; rsp1_valid stays 0.
- ADD overflow on req1: 0x7FFFFFFF + 0x00000001, op=2 -> rsp1_valid; rsp_result=0x80000000; zcv=001; gnt_cnt1=1.
- Tie: both valid continuously, req0 SUB 5-5 op=6, req1 OR 0xF0+0x0F op=1:
  - Grants alternate 0,1,0,1.
  - req0 responses: 0x00000000 with zero=1.
  - req1 responses: 0x000000FF.
  - Each transaction takes 3 cycles with rsp_ready=1.
- Backpressure: rsp0_ready low for 5 cycles -> rsp0_valid and data held for 5 cycles; req1 held off (ready=0) throughout; served right after rsp0_ready.
- Illegal op 4'd3 from req0 -> rsp_err=1, rsp_result=0, zcv=000; alu_ctrl unchanged; gnt_cnt0 increments.
- Mid-EXEC reset -> no rsp valid afterwards; state IDLE; counters 0.
